pcg_share_arbiter: RTL

Round-robin scheduler that shares one 16-bit PCG random generator (LCG ×0x5851 +0x1405, xorshift, 3-bit rotate → 8-bit output) among NREQ requesters. The requesters are VGA effect units. It grants at most one draw per cycle and advances the generator only on a grant, so each requester gets a unique, deterministic value. Results come back through a shared tagged response bus. A seed port reloads the generator state at runtime.

---
 rtl/pcg_share_arbiter_pkg.sv | 23 ++
 rtl/pcg_share_arbiter_core.sv | 66 ++++++
 rtl/pcg_share_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/pcg_share_arbiter_pkg.sv
// Shared constants, state type and output-mixing helpers for the PCG arbiter.
// The helpers are pure functions used by the generator core.
package pcg_share_arbiter_pkg;

  localparam logic [15:0] PCG_MULT = 16'h5851;
  localparam logic [15:0] PCG_INC  = 16'h1405;

  typedef logic [15:0] pcg_state_t;

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] r);
    // A shift by 8 (r == 0) yields zero, so the OR degenerates to x.
    return (x >> r) | (x << (4'd8 - {1'b0, r}));
  endfunction

  function automatic pcg_state_t pcg_next(input pcg_state_t s);
    return s * PCG_MULT + PCG_INC;
  endfunction

  function automatic logic [7:0] pcg_xs(input pcg_state_t s);
    return 8'(((s >> 1) ^ s) >> 3);
  endfunction

endpackage

// File: rtl/pcg_share_arbiter_core.sv
// 16-bit LCG state plus two output stages (xorshift/rotate), tag travels alongside.
// Latency 2 from adv to v; no backpressure, the consumer must take data while v is high.
module pcg8_core
  import pcg_share_arbiter_pkg::*;
#(
  parameter int         TAGW      = 2,
  parameter pcg_state_t SEED_INIT = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic            load,
  input  pcg_state_t      load_val,
  input  logic [TAGW-1:0] tag_in,
  input  logic            v_in,
  output logic [7:0]      data,
  output logic [TAGW-1:0] tag,
  output logic            v
);

  pcg_state_t      s_q, s_d;
  logic [7:0]      xs_q;
  logic [2:0]      rot_q;
  logic            v1_q;
  logic [TAGW-1:0] id1_q;
  logic [7:0]      data_q;
  logic [TAGW-1:0] tag_q;
  logic            v_q;

  // A load overrides an advance; the top never asserts both together.
  always_comb begin
    s_d = s_q;
    if (load) begin
      s_d = load_val;
    end else if (adv) begin
      s_d = pcg_next(s_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= SEED_INIT;
      xs_q   <= '0;
      rot_q  <= '0;
      v1_q   <= 1'b0;
      id1_q  <= '0;
      data_q <= '0;
      tag_q  <= '0;
      v_q    <= 1'b0;
    end else begin
      s_q    <= s_d;
      xs_q   <= pcg_xs(s_q);
      rot_q  <= s_q[5:3];
      v1_q   <= v_in;
      id1_q  <= tag_in;
      data_q <= rotr8(xs_q, rot_q);
      tag_q  <= id1_q;
      v_q    <= v1_q;
    end
  end

  assign data = data_q;
  assign tag  = tag_q;
  assign v    = v_q;

endmodule

// File: rtl/pcg_share_arbiter.sv
// Round-robin arbiter sharing one PCG generator; grant is combinational, response 2 cycles later.
// No backpressure on responses; a seed load blocks grants for that cycle.
module pcg_share_arbiter
  import pcg_share_arbiter_pkg::*;
#(
  parameter int         NREQ      = 4,
  parameter pcg_state_t SEED_INIT = 16'h0000,
  localparam int        IDW       = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  input  logic            seed_valid,
  input  pcg_state_t      seed,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [7:0]      rsp_data,
  output logic [15:0]     draw_count
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_idx;

  // First active requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'(idx);
      end
    end
    if (rst || seed_valid) begin
      gnt_vld = 1'b0;
    end
  end

  assign gnt = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (gnt_vld) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign draw_count = cnt_q;

  pcg8_core #(
    .TAGW      (IDW),
    .SEED_INIT (SEED_INIT)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .adv      (gnt_vld),
    .load     (seed_valid),
    .load_val (seed),
    .tag_in   (gnt_idx),
    .v_in     (gnt_vld),
    .data     (rsp_data),
    .tag      (rsp_id),
    .v        (rsp_valid)
  );

endmodule
